mem_responder: RTL and testbench

//  Target (memory) side of the mem_intf read/write protocol: a 32x8 synchronous

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array.sv | 45 ++++
 rtl/mem_responder.sv | 95 +++++++++
 tb/tb_mem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_intf target-side responder.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned WCNT_W     = 4;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [MEM_DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with one synchronous write/read port and optional clear on reset.
module mem_array #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (we) begin
          mem_q[addr] <= wdata;
        end
      end
    end else begin : g_keep
      // Contents survive reset; only the controller state is cleared.
      always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory target for the mem_intf read/write protocol: wait-state FSM, ready handshake and
// protocol-error pulse in front of a mem_array store.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              error
);

  state_t              state_q;
  logic [WCNT_W-1:0]   cnt_q;
  logic                ready_q;
  logic                error_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_we;
  logic                mem_re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (read && write) begin
            error_q <= 1'b1;
          end else if (read || write) begin
            op_wr_q <= write;
            addr_q  <= addr;
            wdata_q <= data_in;
            ready_q <= 1'b0;
            cnt_q   <= WCNT_W'(WAIT_STATES);
            state_q <= (WAIT_STATES > 0) ? StWait : StAccess;
          end
        end
        StWait: begin
          // Strobes while busy are flagged but never disturb the in-flight op.
          error_q <= read | write;
          cnt_q   <= cnt_q - WCNT_W'(1);
          if (cnt_q == WCNT_W'(1)) state_q <= StAccess;
        end
        StAccess: begin
          error_q <= read | write;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_we = (state_q == StAccess) &&  op_wr_q;
  assign mem_re = (state_q == StAccess) && !op_wr_q;

  mem_array #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (data_out)
  );

  assign ready = ready_q;
  assign error = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed protocol cases plus random traffic
// against an array model of the store.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned WS = 3;

  logic  clk;
  logic  rst;
  logic  read;
  logic  write;
  addr_t addr;
  data_t data_in;
  data_t data_out;
  logic  ready;
  logic  error;

  int checks   = 0;
  int failures = 0;

  data_t model_mem [32];
  data_t model_dout;

  mem_responder #(
    .ADDR_W         (5),
    .DATA_W         (8),
    .WAIT_STATES    (WS),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    model_dout = '0;
  endtask

  // Entered at a negedge with ready=1; returns at the negedge where ready is high again.
  task automatic do_op(input bit is_wr, input addr_t a, input data_t d, input bit poke);
    int lat;
    check("ready_before_req", {31'd0, ready}, 32'd1);
    read    = !is_wr;
    write   = is_wr;
    addr    = a;
    data_in = d;
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    check("error_after_req", {31'd0, error}, 32'd0);
    lat = 0;
    while (ready !== 1'b1 && lat < 64) begin
      lat++;
      if (poke && lat == 1) read = 1'b1;
      @(negedge clk);
      if (poke && lat == 1) begin
        read = 1'b0;
        check("busy_error_pulse", {31'd0, error}, 32'd1);
      end
    end
    check("latency", lat, WS + 1);
    if (is_wr) model_mem[a] = d;
    else model_dout = model_mem[a];
    check("data_out", {24'd0, data_out}, {24'd0, model_dout});
    check("error_at_done", {31'd0, error}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;
    model_reset();
    #12;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Clear pattern, then data=addr pattern.
    for (int i = 0; i < 32; i++) do_op(1'b1, addr_t'(i), 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) do_op(1'b0, addr_t'(i), 8'hff, 1'b0);
    for (int i = 0; i < 32; i++) do_op(1'b1, addr_t'(i), data_t'(i), 1'b0);
    for (int i = 0; i < 32; i++) do_op(1'b0, addr_t'(i), 8'h00, 1'b0);
    do_op(1'b0, 5'd5, 8'h00, 1'b0);
    check("latency_read5_data", {24'd0, data_out}, 32'd5);

    // Read and write together in idle: error pulse, no capture.
    read    = 1'b1;
    write   = 1'b1;
    addr    = 5'd9;
    data_in = 8'hee;
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    check("collision_error", {31'd0, error}, 32'd1);
    check("collision_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    check("collision_error_clear", {31'd0, error}, 32'd0);
    do_op(1'b0, 5'd9, 8'h00, 1'b0);

    // Strobe during wait states must not disturb the in-flight write.
    do_op(1'b1, 5'd3, 8'ha5, 1'b1);
    do_op(1'b0, 5'd3, 8'h00, 1'b0);
    check("busy_mem3", {24'd0, data_out}, 32'h0000_00a5);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      do_op(1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 31)),
            data_t'($urandom_range(0, 255)), 1'b0);
    end

    // Reset in the middle of a write aborts it and clears the store.
    read    = 1'b0;
    write   = 1'b1;
    addr    = 5'd7;
    data_in = 8'h41;
    @(negedge clk);
    write = 1'b0;
    check("midop_busy", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("midop_reset_ready", {31'd0, ready}, 32'd1);
    check("midop_reset_data_out", {24'd0, data_out}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(1'b0, 5'd7, 8'h00, 1'b0);
    check("midop_mem7", {24'd0, data_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
